dot_fp_chunk_seq: RTL and testbench

- Sequencer that computes long floating-point dot products on one shared k-wide `dot_fp` datapath.
- A vector pair of length `len*k` arrives as `len` consecutive k-element chunks on a valid/ready stream.
- Each chunk goes through the `dot_fp` instance; the block registers each partial, accumulates them in a wide signed accumulator, and returns one result per vector pair on a valid/ready output.
- It sits between the MX block loader and the result writeback.

---
 rtl/dot_fp_chunk_seq.sv | 146 ++++++++++++++
 tb/tb_dot_fp_chunk_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dot_fp_chunk_seq.sv
// Chunked floating-point dot-product sequencer: one shared k-wide dot_fp datapath,
// a registered partial stage and a wide accumulator, one result per vector pair.

module dot_fp #(
  parameter int exp_width = 5,
  parameter int man_width = 2,
  parameter int k         = 32,
  parameter int bit_width = 1 + exp_width + man_width,
  parameter int fix_width = (1 << exp_width) + man_width,
  parameter int prd_width = 2 * fix_width,
  parameter int out_width = prd_width + $clog2(k)
) (
  input  logic [bit_width-1:0]        a [k],
  input  logic [bit_width-1:0]        b [k],
  output logic signed [out_width-1:0] dp
);

  // Each element becomes an exact signed fixed-point value in units of the smallest subnormal.
  function automatic logic signed [fix_width-1:0] to_fixed(input logic [bit_width-1:0] e);
    logic [exp_width-1:0] ex;
    logic [fix_width-1:0] mag;
    ex = e[man_width +: exp_width];
    if (ex == '0) mag = fix_width'(e[man_width-1:0]);
    else          mag = fix_width'({1'b1, e[man_width-1:0]}) << (ex - 1'b1);
    return e[bit_width-1] ? -mag : mag;
  endfunction

  logic signed [fix_width-1:0] fa  [k];
  logic signed [fix_width-1:0] fb  [k];
  logic signed [prd_width-1:0] prd [k];

  for (genvar gi = 0; gi < k; gi++) begin : g_lane
    assign fa[gi]  = to_fixed(a[gi]);
    assign fb[gi]  = to_fixed(b[gi]);
    assign prd[gi] = prd_width'(fa[gi]) * prd_width'(fb[gi]);
  end

  always_comb begin
    dp = '0;
    for (int i = 0; i < k; i++) dp = dp + out_width'(prd[i]);
  end

endmodule

module dot_fp_chunk_seq #(
  parameter int exp_width  = 5,
  parameter int man_width  = 2,
  parameter int k          = 32,
  parameter int max_chunks = 16,
  parameter int bit_width  = 1 + exp_width + man_width,
  parameter int prd_width  = 2 * ((1 << exp_width) + man_width),
  parameter int out_width  = prd_width + $clog2(k),
  parameter int len_width  = $clog2(max_chunks + 1),
  parameter int acc_width  = out_width + $clog2(max_chunks)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [len_width-1:0]        i_len,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [bit_width-1:0]        i_vec_a [k],
  input  logic [bit_width-1:0]        i_vec_b [k],
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [acc_width-1:0] o_dp,
  output logic                        o_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state, state_next;
  logic [len_width-1:0]         cnt, cnt_inc, len_reg, len_clean;
  logic                         accept;
  logic signed [out_width-1:0]  dp;
  logic signed [out_width-1:0]  p1_dp;
  logic                         p1_vld, p1_first;
  logic signed [acc_width-1:0]  acc;

  dot_fp #(
    .exp_width(exp_width),
    .man_width(man_width),
    .k        (k)
  ) u_dot (
    .a (i_vec_a),
    .b (i_vec_b),
    .dp(dp)
  );

  assign o_ready = !i_rst && (state == IDLE || state == RUN);
  assign accept  = i_valid && o_ready;
  assign o_busy  = (state != IDLE);
  assign cnt_inc = cnt + len_width'(1);

  always_comb begin
    len_clean = i_len;
    if (i_len == '0)                             len_clean = len_width'(1);
    else if (i_len > len_width'(max_chunks))     len_clean = len_width'(max_chunks);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (len_clean == len_width'(1)) ? DRAIN : RUN;
      RUN:     if (accept && cnt_inc == len_reg) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (o_valid && i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len_reg  <= '0;
      p1_dp    <= '0;
      p1_vld   <= 1'b0;
      p1_first <= 1'b0;
      acc      <= '0;
      o_valid  <= 1'b0;
      o_dp     <= '0;
    end else begin
      state  <= state_next;
      p1_vld <= accept;
      if (accept) begin
        p1_dp    <= dp;
        p1_first <= (state == IDLE);
        if (state == IDLE) begin
          len_reg <= len_clean;
          cnt     <= len_width'(1);
        end else begin
          cnt <= cnt_inc;
        end
      end
      // The first partial of a pair overwrites whatever the previous pair left behind.
      if (p1_vld) acc <= p1_first ? acc_width'(p1_dp) : acc + acc_width'(p1_dp);
      if (state == DONE && !o_valid) begin
        o_valid <= 1'b1;
        o_dp    <= acc;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_fp_chunk_seq.sv
// Self-checking bench for dot_fp_chunk_seq: directed edge cases plus random jobs
// checked against an exact scaled-integer model of E5M2 dot products.

module tb_dot_fp_chunk_seq;
  localparam int EW = 5, MW = 2, K = 32, MAXC = 16;
  localparam int BW = 1 + EW + MW;
  localparam int PW = 2 * ((1 << EW) + MW);
  localparam int OW = PW + $clog2(K);
  localparam int LW = $clog2(MAXC + 1);
  localparam int AW = OW + $clog2(MAXC);
  // One chunk of 32 x (1.0 * 1.0), in units of 2^-16 squared.
  localparam logic signed [127:0] D1 = 128'sd1 <<< 37;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [LW-1:0] len;
  logic valid, ready_in, rdy, vld, busy;
  logic [BW-1:0] va [K];
  logic [BW-1:0] vb [K];
  logic signed [AW-1:0] dp;

  dot_fp_chunk_seq #(.exp_width(EW), .man_width(MW), .k(K), .max_chunks(MAXC)) dut (
    .i_clk(clk), .i_rst(rst), .i_len(len), .i_valid(valid), .o_ready(rdy),
    .i_vec_a(va), .i_vec_b(vb), .o_valid(vld), .i_ready(ready_in), .o_dp(dp), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int last_acc, first_acc, hs;
  logic signed [127:0] exp_sum;

  task automatic check(input string tag, input logic signed [127:0] got, input logic signed [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Element value multiplied by 2^16 (smallest E5M2 subnormal is 2^-16).
  function automatic logic signed [127:0] elem_scaled(input logic [7:0] e);
    int ex, m;
    logic signed [127:0] v;
    ex = int'(e[6:2]);
    m  = int'(e[1:0]);
    if (ex == 0) v = 128'(m);
    else         v = 128'(4 + m) <<< (ex - 1);
    return e[7] ? -v : v;
  endfunction

  function automatic logic signed [127:0] chunk_dot();
    logic signed [127:0] s = 0;
    for (int i = 0; i < K; i++) s += elem_scaled(va[i]) * elem_scaled(vb[i]);
    return s;
  endfunction

  task automatic fill(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < K; i++) begin va[i] = a; vb[i] = b; end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < K; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
  endtask

  task automatic send_chunk();
    int n = 0;
    valid = 1'b1;
    exp_sum += chunk_dot();
    @(negedge clk);
    while (!rdy && n < 200) begin n++; @(negedge clk); end
    if (!rdy) begin
      check("accept_timeout", 0, 1);
      valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    last_acc = cyc;
    valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic signed [127:0] want);
    int n = 0;
    ready_in = 1'b1;
    @(negedge clk);
    while (!vld && n < 50) begin
      check({tag, "_rdy_wait"}, rdy, 0);
      check({tag, "_busy_wait"}, busy, 1);
      n++;
      @(negedge clk);
    end
    if (!vld) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_lat"}, cyc - last_acc, 2);
    check({tag, "_dp"}, dp, want);
    check({tag, "_rdy_done"}, rdy, 0);
    @(posedge clk); #1;
    check({tag, "_vld_drop"}, vld, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_rdy_idle"}, rdy, 1);
  endtask

  initial begin
    valid = 1'b0; ready_in = 1'b1; len = 1; exp_sum = 0;
    fill(8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy_low", rdy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy", rdy, 1);
    check("rst_vld", vld, 0);
    check("rst_dp", dp, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;

    // single chunk
    len = 1; fill(8'h3C, 8'h3C);
    send_chunk();
    wait_result("single", D1);

    // four back-to-back chunks
    len = 4; fill(8'h3C, 8'h3C);
    send_chunk(); first_acc = last_acc;
    for (int c = 1; c < 4; c++) send_chunk();
    check("b2b_span", last_acc - first_acc, 3);
    wait_result("four", 4 * D1);

    // signed mix with 2-cycle bubbles
    len = 3;
    fill(8'h3C, 8'h3C); send_chunk();
    repeat (2) @(posedge clk); #1;
    fill(8'hBC, 8'h3C); send_chunk();
    repeat (2) @(posedge clk); #1;
    fill(8'h3C, 8'h3C); send_chunk();
    wait_result("mix", D1);

    // backpressure in DONE with a chunk offered meanwhile
    len = 1; fill(8'h3C, 8'h3C);
    send_chunk();
    ready_in = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!vld && n < 50) begin n++; @(negedge clk); end
    end
    check("bp_lat", cyc - last_acc, 2);
    check("bp_dp", dp, D1);
    valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_vld_hold", vld, 1);
      check("bp_dp_hold", dp, D1);
      check("bp_rdy_low", rdy, 0);
    end
    ready_in = 1'b1;
    @(posedge clk); #1;
    hs = cyc;
    check("bp_vld_drop", vld, 0);
    send_chunk();
    check("bp_next_accept", last_acc - hs, 1);
    wait_result("bp_next", D1);

    // length edges
    len = 0; fill(8'h3C, 8'h3C);
    send_chunk();
    wait_result("len0", D1);

    len = 20;
    for (int c = 0; c < 16; c++) send_chunk();
    wait_result("len_clamp", 16 * D1);

    len = 2;
    send_chunk();
    len = 5;
    send_chunk();
    wait_result("len_change", 2 * D1);

    // reset in the middle of RUN
    len = 4;
    send_chunk(); send_chunk();
    rst = 1'b1;
    @(negedge clk);
    check("mrst_rdy_low", rdy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_rdy", rdy, 1);
    check("mrst_vld", vld, 0);
    check("mrst_busy", busy, 0);
    @(posedge clk); #1;
    len = 1;
    send_chunk();
    wait_result("mrst_next", D1);

    // random jobs against the model
    for (int j = 0; j < 8; j++) begin
      int n;
      n = int'($urandom_range(1, 5));
      len = LW'(n);
      exp_sum = 0;
      for (int c = 0; c < n; c++) begin
        int gap;
        fill_rand();
        send_chunk();
        gap = int'($urandom_range(0, 2));
        if (gap > 0 && c < n - 1) begin
          repeat (gap) @(posedge clk);
          #1;
        end
      end
      wait_result("rnd", exp_sum);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
